// File: rtl/armleocpu_writeback.sv
// armleocpu_writeback: final pipeline stage that retires ALU results and load data into the regfile write port.
//   clk, rst_n                      : clock, async active-low reset
//   e_valid/e_ready                 : accept handshake from execute (e_ready only in IDLE)
//   e_rd_write/e_rd_addr/e_result   : destination and ALU result
//   e_is_load/e_load_type/e_addr_lo : load descriptor (funct3, low address bits)
//   m_rvalid/m_rdata/m_err          : load response from data memory
//   rd_write/rd_addr/rd_wdata       : registered single-cycle regfile write
//   load_pending                    : load outstanding, for hazard logic
//   load_fault/load_fault_rd        : single-cycle fault pulse on error or timeout
module armleocpu_writeback #(
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_valid,
  output logic        e_ready,
  input  logic        e_rd_write,
  input  logic [4:0]  e_rd_addr,
  input  logic [31:0] e_result,
  input  logic        e_is_load,
  input  logic [2:0]  e_load_type,
  input  logic [1:0]  e_addr_lo,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err,
  output logic        rd_write,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_wdata,
  output logic        load_pending,
  output logic        load_fault,
  output logic [4:0]  load_fault_rd
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  localparam logic [15:0] TO_LAST = 16'(LOAD_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        lw_q, lw_d;
  logic [4:0]  lrd_q, lrd_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  llo_q, llo_d;
  logic        rd_write_q, rd_write_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_wdata_q, rd_wdata_d;
  logic        fault_q, fault_d;
  logic [4:0]  frd_q, frd_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_data;
  assign byte_v = m_rdata[{llo_q, 3'b000} +: 8];
  assign half_v = llo_q[1] ? m_rdata[31:16] : m_rdata[15:0];
  // reserved funct3 encodings fall through to the full word
  assign load_data = ltype_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                     ltype_q == 3'b100 ? {24'b0, byte_v} :
                     ltype_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                     ltype_q == 3'b101 ? {16'b0, half_v} : m_rdata;
  assign e_ready       = state_q == IDLE;
  assign load_pending  = state_q == WAIT_LOAD;
  assign rd_write      = rd_write_q;
  assign rd_addr       = rd_addr_q;
  assign rd_wdata      = rd_wdata_q;
  assign load_fault    = fault_q;
  assign load_fault_rd = frd_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lw_d       = lw_q;
    lrd_d      = lrd_q;
    ltype_d    = ltype_q;
    llo_d      = llo_q;
    rd_write_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_wdata_d = rd_wdata_q;
    fault_d    = 1'b0;
    frd_d      = frd_q;
    if (state_q == IDLE) begin
      if (e_valid && !e_is_load) begin
        rd_write_d = e_rd_write && e_rd_addr != 5'd0;
        rd_addr_d  = e_rd_addr;
        rd_wdata_d = e_result;
      end else if (e_valid) begin
        lw_d    = e_rd_write;
        lrd_d   = e_rd_addr;
        ltype_d = e_load_type;
        llo_d   = e_addr_lo;
        cnt_d   = '0;
        state_d = WAIT_LOAD;
      end
    end else if (m_rvalid) begin
      state_d = IDLE;
      if (m_err) begin
        fault_d = 1'b1;
        frd_d   = lrd_q;
      end else begin
        rd_write_d = lw_q && lrd_q != 5'd0;
        rd_addr_d  = lrd_q;
        rd_wdata_d = load_data;
      end
    end else if (cnt_q == TO_LAST) begin
      // this cycle completes the allowed wait; a response here would have won above
      state_d = IDLE;
      fault_d = 1'b1;
      frd_d   = lrd_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      lw_q       <= 1'b0;
      lrd_q      <= '0;
      ltype_q    <= '0;
      llo_q      <= '0;
      rd_write_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
      fault_q    <= 1'b0;
      frd_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lw_q       <= lw_d;
      lrd_q      <= lrd_d;
      ltype_q    <= ltype_d;
      llo_q      <= llo_d;
      rd_write_q <= rd_write_d;
      rd_addr_q  <= rd_addr_d;
      rd_wdata_q <= rd_wdata_d;
      fault_q    <= fault_d;
      frd_q      <= frd_d;
    end
  end
endmodule

// File: tb/tb_armleocpu_writeback.sv
// tb_armleocpu_writeback: directed and randomized checks of the writeback stage against a transaction-level model.
module tb_armleocpu_writeback;
  localparam int TO = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_valid = 1'b0, e_ready, e_rd_write = 1'b0, e_is_load = 1'b0;
  logic [4:0]  e_rd_addr = '0;
  logic [31:0] e_result = '0;
  logic [2:0]  e_load_type = '0;
  logic [1:0]  e_addr_lo = '0;
  logic        m_rvalid = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        rd_write, load_pending, load_fault;
  logic [4:0]  rd_addr, load_fault_rd;
  logic [31:0] rd_wdata;
  int errors = 0, checks = 0;
  logic        busy, p_w;
  logic [4:0]  p_rd;
  logic [2:0]  p_t;
  logic [1:0]  p_lo;
  int          waited;
  logic        x_wr, x_flt;
  logic [4:0]  x_addr, x_frd;
  logic [31:0] x_data;
  logic [31:0] dut_rf [32];
  armleocpu_writeback #(.LOAD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_ready(e_ready),
    .e_rd_write(e_rd_write), .e_rd_addr(e_rd_addr), .e_result(e_result),
    .e_is_load(e_is_load), .e_load_type(e_load_type), .e_addr_lo(e_addr_lo),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .rd_write(rd_write), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
    .load_pending(load_pending), .load_fault(load_fault), .load_fault_rd(load_fault_rd)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t, input logic [1:0] lo);
    int b, h;
    b = int'((w >> (int'(lo) * 8)) & 32'hFF);
    h = int'((w >> (int'(lo[1]) * 16)) & 32'hFFFF);
    if (t == 3'b000) return 32'(b >= 128 ? b - 256 : b);
    if (t == 3'b100) return 32'(b);
    if (t == 3'b001) return 32'(h >= 32768 ? h - 65536 : h);
    if (t == 3'b101) return 32'(h);
    return w;
  endfunction
  task automatic model_reset();
    busy = 0; p_w = 0; p_rd = 0; p_t = 0; p_lo = 0; waited = 0;
    x_wr = 0; x_flt = 0; x_addr = 0; x_data = 0; x_frd = 0;
  endtask
  task automatic check_outputs();
    chk("rd_write", 32'(rd_write), 32'(x_wr));
    chk("rd_addr", 32'(rd_addr), 32'(x_addr));
    chk("rd_wdata", rd_wdata, x_data);
    chk("load_fault", 32'(load_fault), 32'(x_flt));
    chk("load_fault_rd", 32'(load_fault_rd), 32'(x_frd));
  endtask
  // one clock: check combinational status, advance the model, then check registered outputs
  task automatic cycle();
    chk("e_ready", 32'(e_ready), 32'(!busy));
    chk("load_pending", 32'(load_pending), 32'(busy));
    x_wr = 0; x_flt = 0;
    if (!busy) begin
      if (e_valid && !e_is_load) begin
        x_wr = e_rd_write && e_rd_addr != 0; x_addr = e_rd_addr; x_data = e_result;
      end else if (e_valid) begin
        busy = 1; p_w = e_rd_write; p_rd = e_rd_addr; p_t = e_load_type; p_lo = e_addr_lo; waited = 0;
      end
    end else if (m_rvalid && !m_err) begin
      busy = 0; x_wr = p_w && p_rd != 0; x_addr = p_rd; x_data = ref_load(m_rdata, p_t, p_lo);
    end else if (m_rvalid || waited + 1 == TO) begin
      busy = 0; x_flt = 1; x_frd = p_rd;
    end else waited++;
    @(posedge clk);
    #1;
    if (rd_write) dut_rf[rd_addr] = rd_wdata;
    check_outputs();
  endtask
  task automatic issue(input logic ld, input logic [2:0] t, input logic [1:0] lo, input logic [4:0] rd, input logic [31:0] res);
    e_valid = 1; e_is_load = ld; e_load_type = t; e_addr_lo = lo; e_rd_addr = rd; e_result = res; e_rd_write = 1;
    cycle();
    e_valid = 0;
  endtask
  task automatic mem(input logic rv, input logic err, input logic [31:0] d);
    m_rvalid = rv; m_err = err; m_rdata = d;
    cycle();
    m_rvalid = 0; m_err = 0;
  endtask
  task automatic load_test(input logic [2:0] t, input logic [1:0] lo, input logic [31:0] exp);
    issue(1, t, lo, 5'd3, 32'h0);
    mem(0, 0, 0);
    mem(0, 0, 0);
    mem(1, 0, 32'h12803456);
    chk("load_value", rd_wdata, exp);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) dut_rf[i] = '0;
    model_reset();
    #12;
    check_outputs();
    rst_n = 1;
    @(posedge clk); #1;
    issue(0, 0, 0, 5'd5, 32'hFF00FF00);
    issue(0, 0, 0, 5'd0, 32'h1234);
    chk("rf_x5", dut_rf[5], 32'hFF00FF00);
    load_test(3'b000, 2'd2, 32'hFFFFFF80);
    load_test(3'b100, 2'd2, 32'h00000080);
    load_test(3'b001, 2'd2, 32'h00001280);
    load_test(3'b010, 2'd2, 32'h12803456);
    issue(1, 3'b010, 0, 5'd7, 0);
    mem(1, 1, 32'hDEADBEEF);
    chk("err_fault_rd", 32'(load_fault_rd), 32'd7);
    mem(0, 0, 0);
    issue(1, 3'b010, 0, 5'd9, 0);
    for (int i = 0; i < TO; i++) mem(0, 0, 0);
    chk("timeout_rd", 32'(load_fault_rd), 32'd9);
    issue(1, 3'b010, 0, 5'd9, 0);
    for (int i = 0; i < TO - 1; i++) mem(0, 0, 0);
    mem(1, 0, 32'hCAFEF00D);
    chk("late_resp", rd_wdata, 32'hCAFEF00D);
    mem(1, 0, 32'h55555555);
    e_valid = 1; e_is_load = 1; e_load_type = 3'b010; e_rd_addr = 5'd4; e_rd_write = 1;
    cycle();
    e_is_load = 0; e_rd_addr = 5'd10; e_result = 32'hA5A5A5A5;
    cycle(); cycle();
    m_rvalid = 1; m_rdata = 32'h11112222; cycle(); m_rvalid = 0;
    cycle();
    e_valid = 0;
    cycle();
    chk("rf_x10", dut_rf[10], 32'hA5A5A5A5);
    issue(0, 0, 0, 5'd5, 32'h77);
    issue(1, 3'b010, 0, 5'd6, 0);
    #3 rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("rst_ready", 32'(e_ready), 32'd1);
    chk("rst_pending", 32'(load_pending), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    mem(1, 0, 32'hBAD0BAD0);
    mem(1, 1, 32'hBAD0BAD0);
    for (int n = 0; n < 3000; n++) begin
      e_valid = $urandom_range(0, 2) != 0;
      e_is_load = $urandom_range(0, 1) != 0;
      e_rd_write = $urandom_range(0, 3) != 0;
      e_rd_addr = 5'($urandom_range(0, 31));
      e_result = $urandom;
      e_load_type = 3'($urandom_range(0, 7));
      e_addr_lo = 2'($urandom_range(0, 3));
      m_rvalid = $urandom_range(0, 3) == 0;
      m_err = $urandom_range(0, 4) == 0;
      m_rdata = $urandom;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
